// File: rtl/uart_pkg.sv
// Shared definitions for the parameterised UART transmitter: register map,
// parity encoding and transmit FSM states.
package uart_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_CTRL   = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_BAUD   = 2'd3;

    typedef enum logic [1:0] {
        PAR_NONE  = 2'b00,
        PAR_EVEN  = 2'b01,
        PAR_ODD   = 2'b10,
        PAR_NONE2 = 2'b11
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

endpackage

// File: rtl/uart_tx_param_if.sv
// Register bus between a host and the UART transmitter.
interface uart_tx_param_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] rdata;

    modport master (output addr, wdata, wr_en, rd_en, input rdata);
    modport slave  (input addr, wdata, wr_en, rd_en, output rdata);
endinterface

// File: rtl/uart_fifo.sv
// Circular transmit FIFO; a push while full is accepted only if a pop
// happens in the same cycle.
module uart_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [W-1:0]     i_data,
    output logic [W-1:0]     o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [LVL_W-1:0] o_level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]     r_mem [DEPTH];
    logic [AW-1:0]    r_wptr, r_rptr;
    logic [LVL_W-1:0] r_level;
    logic             w_push, w_pop;

    assign o_full  = (r_level == LVL_W'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_data  = r_mem[r_rptr];
    assign w_push  = i_push & (~o_full | i_pop);
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end
endmodule

// File: rtl/uart_tx_param.sv
// Register-mapped UART transmitter: FIFO-fed frame engine with configurable
// character length, parity, stop bits and baud divisor.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_param_if.slave bus,
    output logic           tx_out,
    output logic           irq
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    state_e             r_state, w_nstate;
    logic [5:0]         r_ctrl;
    logic [DIV_W-1:0]   r_baud, r_baud_lat, r_baud_cnt;
    logic [DATA_W-1:0]  r_last, r_shift;
    logic [3:0]         r_bit_cnt;
    logic               r_ovf, r_par_bit, r_par_en, r_two_stop;

    logic [1:0]         w_sel;
    logic               w_wr_data, w_pop, w_go, w_bit_end, w_busy;
    logic               w_full, w_empty;
    logic [DATA_W-1:0]  w_fifo_data;
    logic [LVL_W-1:0]   w_level;
    parity_e            w_par_mode;
    logic               w_unused;

    assign w_sel      = bus.addr[3:2];
    assign w_wr_data  = bus.wr_en & (w_sel == REG_DATA);
    assign w_par_mode = parity_e'(r_ctrl[3:2]);
    assign w_go       = r_ctrl[0] & (r_baud != '0) & ~w_empty;
    assign w_bit_end  = (r_baud_cnt == r_baud_lat);
    assign w_busy     = (r_state != IDLE);
    assign irq        = (r_ctrl[4] & w_empty & ~w_busy) | (r_ctrl[5] & r_ovf);
    assign w_unused   = ^{bus.addr[31:4], bus.addr[1:0], bus.wdata};

    uart_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_wr_data),
        .i_pop   (w_pop),
        .i_data  (bus.wdata[DATA_W-1:0]),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl <= '0;
            r_baud <= '0;
            r_ovf  <= 1'b0;
            r_last <= '0;
        end else if (bus.wr_en) begin
            case (w_sel)
                REG_DATA: begin
                    if (~w_full | w_pop) r_last <= bus.wdata[DATA_W-1:0];
                    else                 r_ovf  <= 1'b1;
                end
                REG_CTRL:   r_ctrl <= bus.wdata[5:0];
                REG_STATUS: if (bus.wdata[3]) r_ovf <= 1'b0;
                default:    r_baud <= bus.wdata[DIV_W-1:0];
            endcase
        end
    end

    always_comb begin
        bus.rdata = '0;
        if (bus.rd_en) begin
            case (w_sel)
                REG_DATA:   bus.rdata = 32'(r_last);
                REG_CTRL:   bus.rdata = 32'(r_ctrl);
                REG_STATUS: bus.rdata = {15'b0, 9'(w_level), 4'b0, r_ovf, w_busy, w_full, w_empty};
                default:    bus.rdata = 32'(r_baud);
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_nstate;
    end

    // A frame start pops the FIFO in the same cycle, both from IDLE and
    // straight out of the last stop bit.
    always_comb begin
        w_nstate = r_state;
        w_pop    = 1'b0;
        case (r_state)
            IDLE: if (w_go) begin
                w_nstate = START;
                w_pop    = 1'b1;
            end
            START:  if (w_bit_end) w_nstate = DATA;
            DATA:   if (w_bit_end && r_bit_cnt == 4'(DATA_W - 1))
                        w_nstate = r_par_en ? PARITY : STOP;
            PARITY: if (w_bit_end) w_nstate = STOP;
            STOP: if (w_bit_end && r_bit_cnt == {3'b0, r_two_stop}) begin
                w_nstate = w_go ? START : IDLE;
                w_pop    = w_go;
            end
            default: w_nstate = IDLE;
        endcase
    end

    // Frame settings are snapshotted at the pop so mid-frame register writes
    // only affect the next frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift    <= '0;
            r_par_bit  <= 1'b0;
            r_par_en   <= 1'b0;
            r_two_stop <= 1'b0;
            r_baud_lat <= '0;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
        end else if (w_pop) begin
            r_shift    <= w_fifo_data;
            r_par_bit  <= (^w_fifo_data) ^ (w_par_mode == PAR_ODD);
            r_par_en   <= (w_par_mode == PAR_EVEN) | (w_par_mode == PAR_ODD);
            r_two_stop <= r_ctrl[1];
            r_baud_lat <= r_baud;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
        end else if (r_state != IDLE) begin
            if (w_bit_end) begin
                r_baud_cnt <= '0;
                r_bit_cnt  <= (w_nstate != r_state) ? 4'd0 : r_bit_cnt + 4'd1;
                if (r_state == DATA) r_shift <= r_shift >> 1;
            end else begin
                r_baud_cnt <= r_baud_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        tx_out = 1'b1;
        case (r_state)
            START:   tx_out = 1'b0;
            DATA:    tx_out = r_shift[0];
            PARITY:  tx_out = r_par_bit;
            default: tx_out = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: frame shape/timing, parity, back-to-back,
// mid-frame config changes, FIFO overflow, interrupts and reset abort.
module tb_uart_tx_param;
    localparam logic [31:0] A_DATA = 32'h0, A_CTRL = 32'h4, A_STAT = 32'h8, A_BAUD = 32'hC;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tx_out, irq;
    int   n_tests = 0;
    int   n_fail = 0;
    logic [31:0] d;

    uart_tx_param_if bus();

    uart_tx_param #(.DATA_W(8), .FIFO_DEPTH(4), .DIV_W(16)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .tx_out (tx_out),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] v);
        @(negedge clk);
        bus.addr  = a;
        bus.wdata = v;
        bus.wr_en = 1'b1;
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        bus.addr  = a;
        bus.rd_en = 1'b1;
        #1;
        v = bus.rdata;
        bus.rd_en = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // bits[0] is the first bit on the line; each bit is checked on every cycle.
    task automatic frame(input string tag, input logic [15:0] bits, input int nbits,
                         input int blen, input int budget, input bit chk_busy);
        int w;
        logic [31:0] st;
        w = 0;
        while (tx_out !== 1'b0 && w < budget) begin
            @(negedge clk);
            w++;
        end
        for (int i = 0; i < nbits; i++) begin
            for (int c = 0; c < blen; c++) begin
                chk($sformatf("%s bit%0d cyc%0d", tag, i, c), 32'(tx_out), 32'(bits[i]));
                if (chk_busy) begin
                    rd(A_STAT, st);
                    chk($sformatf("%s busy bit%0d", tag, i), 32'(st[2]), 32'd1);
                end
                @(negedge clk);
            end
        end
    endtask

    initial begin
        bus.addr = '0; bus.wdata = '0; bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        chk("rst tx_out", 32'(tx_out), 32'd1);
        chk("rst irq", 32'(irq), 32'd0);
        bus.addr = A_STAT; #1;
        chk("rst rdata idle", bus.rdata, 32'd0);
        rd(A_STAT, d); chk("rst status", d, 32'h1);
        rd(A_CTRL, d); chk("rst ctrl", d, 32'h0);

        // 0xA5, no parity, one stop, 4-cycle bits
        wr(A_BAUD, 32'd3);
        wr(A_CTRL, 32'h1);
        wr(A_DATA, 32'hA5);
        frame("a5", {6'b0, 1'b1, 8'hA5, 1'b0}, 10, 4, 4, 1'b1);
        chk("a5 idle tx", 32'(tx_out), 32'd1);
        rd(A_STAT, d); chk("a5 status after", d, 32'h1);
        rd(A_DATA, d); chk("data readback", d, 32'hA5);

        // odd parity, two stop bits
        wr(A_CTRL, 32'h0B);
        wr(A_DATA, 32'h03);
        frame("odd", {4'b0, 3'b111, 8'h03, 1'b0}, 12, 4, 4, 1'b1);
        chk("odd idle tx", 32'(tx_out), 32'd1);
        rd(A_STAT, d); chk("odd status after", d, 32'h1);

        // three queued words go out back-to-back
        wr(A_CTRL, 32'h0);
        wr(A_BAUD, 32'd1);
        wr(A_DATA, 32'h11);
        wr(A_DATA, 32'h22);
        wr(A_DATA, 32'h33);
        rd(A_STAT, d); chk("b2b level3", d, 32'h300);
        wr(A_CTRL, 32'h1);
        frame("b2b0", {6'b0, 1'b1, 8'h11, 1'b0}, 10, 2, 3, 1'b1);
        frame("b2b1", {6'b0, 1'b1, 8'h22, 1'b0}, 10, 2, 0, 1'b1);
        frame("b2b2", {6'b0, 1'b1, 8'h33, 1'b0}, 10, 2, 0, 1'b1);
        chk("b2b idle tx", 32'(tx_out), 32'd1);
        rd(A_STAT, d); chk("b2b status after", d, 32'h1);

        // BAUD 3 -> 7 during the first frame
        wr(A_CTRL, 32'h0);
        wr(A_BAUD, 32'd3);
        wr(A_DATA, 32'h5A);
        wr(A_DATA, 32'hC3);
        wr(A_CTRL, 32'h1);
        fork
            begin
                frame("baud4", {6'b0, 1'b1, 8'h5A, 1'b0}, 10, 4, 3, 1'b0);
                frame("baud8", {6'b0, 1'b1, 8'hC3, 1'b0}, 10, 8, 0, 1'b0);
            end
            begin
                repeat (12) @(negedge clk);
                wr(A_BAUD, 32'd7);
            end
        join
        chk("baud idle tx", 32'(tx_out), 32'd1);
        rd(A_BAUD, d); chk("baud readback", d, 32'd7);

        // tx_en cleared mid-frame: frame completes, second word stays queued
        wr(A_CTRL, 32'h0);
        wr(A_BAUD, 32'd1);
        wr(A_DATA, 32'h0F);
        wr(A_DATA, 32'hF0);
        wr(A_CTRL, 32'h1);
        fork
            frame("txen", {6'b0, 1'b1, 8'h0F, 1'b0}, 10, 2, 3, 1'b0);
            begin
                repeat (6) @(negedge clk);
                wr(A_CTRL, 32'h0);
            end
        join
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("txen hold idle %0d", k), 32'(tx_out), 32'd1);
            @(negedge clk);
        end
        rd(A_STAT, d); chk("txen status", d, 32'h100);

        // overflow on a 4-deep FIFO
        pulse_reset();
        wr(A_CTRL, 32'h20);
        for (int k = 1; k <= 5; k++) wr(A_DATA, 32'(k));
        rd(A_STAT, d); chk("ovf status", d, 32'h40A);
        chk("ovf irq", 32'(irq), 32'd1);
        wr(A_STAT, 32'h8);
        rd(A_STAT, d); chk("ovf cleared status", d, 32'h402);
        chk("ovf cleared irq", 32'(irq), 32'd0);

        // reset in the middle of the DATA state
        wr(A_BAUD, 32'd3);
        wr(A_CTRL, 32'h1);
        repeat (10) @(negedge clk);
        rd(A_STAT, d); chk("mid frame status", d, 32'h304);
        pulse_reset();
        chk("abort tx_out", 32'(tx_out), 32'd1);
        chk("abort irq", 32'(irq), 32'd0);
        rd(A_STAT, d); chk("abort status", d, 32'h1);
        rd(A_CTRL, d); chk("abort ctrl", d, 32'h0);
        rd(A_BAUD, d); chk("abort baud", d, 32'h0);
        bus.addr = A_STAT; #1;
        chk("abort rdata idle", bus.rdata, 32'd0);
        @(negedge clk);
        chk("abort tx_out hold", 32'(tx_out), 32'd1);

        // empty interrupt
        wr(A_CTRL, 32'h10);
        chk("irq empty", 32'(irq), 32'd1);
        wr(A_DATA, 32'h55);
        chk("irq not empty", 32'(irq), 32'd0);
        rd(A_STAT, d); chk("irq status", d, 32'h100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning character length in bits (legal 5..9).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning transmit FIFO entries (power of two, 2..256).
REQ-003 SHALL have parameter DIV_W, default 16, meaning baud divisor width.
REQ-004 SHALL have port clk input 1, system clock.
REQ-005 SHALL have port reset input 1: reset reset, synchronous, active-high; clock clk.
REQ-006 SHALL have port addr input 32, byte address; only bits [3:2] decoded.
REQ-007 SHALL have port wdata input 32, write data.
REQ-008 SHALL have port wr_en input 1, single-cycle write strobe.
REQ-009 SHALL have port rd_en input 1, read strobe.
REQ-010 SHALL have port rdata output 32, read data.
REQ-011 SHALL have port tx_out output 1, serial line, idle high.
REQ-012 SHALL have port irq output 1, level interrupt.

Function
REQ-013 SHALL map 0x0 DATA (write pushes wdata[DATA_W-1:0]; read returns last pushed word), 0x4 CTRL, 0x8 STATUS, 0xC BAUD (divisor, DIV_W bits).
REQ-014 CTRL SHALL be: bit0 tx_en, bit1 two_stop, bits[3:2] parity (00 none, 01 even, 10 odd, 11 treated as none), bit4 irq_empty_en, bit5 irq_ovf_en.
REQ-015 STATUS SHALL be: bit0 fifo_empty, bit1 fifo_full, bit2 busy, bit3 overflow (sticky, write 1 to clear), bits[16:8] fifo level.
REQ-016 rdata SHALL be combinational from addr when rd_en=1, zero when rd_en=0 or addr unmapped.
REQ-017 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-018 IDLE->START when tx_en=1, BAUD!=0, FIFO non-empty; FIFO pop and latch of word, parity mode, two_stop occur in that same cycle.
REQ-019 Each bit SHALL last exactly BAUD+1 clk cycles, counted by a baud counter cleared on every bit boundary.
REQ-020 Bits SHALL be sent start(0), DATA_W data LSB-first, parity if enabled, then 1 or 2 stop bits(1).
REQ-021 Even parity bit SHALL equal XOR of data bits; odd parity its inverse.
REQ-022 After last stop bit: if start conditions (REQ-018) hold, go directly to START (back-to-back, no idle gap); else IDLE.
REQ-023 CTRL/BAUD writes mid-frame SHALL take effect only from the next frame start.
REQ-024 Clearing tx_en mid-frame SHALL complete the current frame, then hold IDLE.
REQ-025 Push when full SHALL be dropped and set overflow; push and pop in the same cycle when full SHALL be accepted.
REQ-026 Push and pop in the same cycle SHALL leave level unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-027 busy SHALL be 1 in any state other than IDLE.
REQ-028 irq SHALL equal (irq_empty_en & fifo_empty & !busy) | (irq_ovf_en & overflow).
REQ-029 tx_out SHALL be 1 in IDLE and whenever not driving a frame bit.

Reset
REQ-030 Reset SHALL clear CTRL, BAUD, FIFO pointers/level, overflow, counters; FSM->IDLE.
REQ-031 After reset: tx_out=1, irq=0, rdata=0; reset mid-frame aborts immediately with tx_out=1 next cycle.

Structure
REQ-032 Package uart_pkg SHALL hold register offsets, parity enum, FSM state enum.
REQ-033 FIFO SHALL be sub-module uart_fifo (parameterised width/depth, push/pop, full/empty/level).
REQ-034 Shift register, parity, baud and bit counters SHALL reside in uart_tx_param.

Verification
REQ-035 BAUD=3, parity none, 1 stop, push 0xA5 -> tx_out 0,1,0,1,0,0,1,0,1,1, each 4 cycles; busy 40 cycles.
REQ-036 Parity odd, two_stop, push 0x03 -> 8 data bits then parity 1 then two stop bits; frame 12 bit-times.
REQ-037 Push 3 words with tx_en=1 -> three frames back-to-back with no idle cycle between stop and start.
REQ-038 FIFO_DEPTH=4, tx_en=0, push 5 words -> level 4, full=1, overflow=1, irq=1 with irq_ovf_en; write 0x8 bit3=1 clears.
REQ-039 Change BAUD 3->7 mid-frame -> current frame keeps 4-cycle bits, next frame 8-cycle bits.
REQ-040 Assert reset mid DATA state -> tx_out=1, level=0, STATUS busy=0 next cycle.
